// File: rtl/lane_merge_rr_pkg.sv
// Shared constants and helpers for the lane merger and its picker.
package lane_merge_rr_pkg;

    localparam logic MODE_TDM = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2; used to size lane indices at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping mod NUM_LANES.
module lane_rr_pick
    import lane_merge_rr_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    localparam int SEL_W     = clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     grant,
    output logic                 any
);

    // Scan farthest-first so the lane closest to ptr overwrites last and wins;
    // NUM_LANES is a power of two, so index arithmetic wraps naturally.
    always_comb begin
        grant = '0;
        any   = |req;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) grant = ptr + SEL_W'(k);
        end
    end

endmodule

// File: rtl/lane_merge_rr.sv
// N-to-1 lane merger with registered output, valid/ready on every port,
// and internally generated lane selection (fixed TDM or work-conserving RR).
module lane_merge_rr
    import lane_merge_rr_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_LANES  = 4,
    localparam int SEL_W      = clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_LANES-1:0]            valid_in,
    output logic [NUM_LANES-1:0]            ready_out,
    input  logic                            mode,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic [SEL_W-1:0]                lane_out,
    input  logic                            ready_in
);

    logic [DATA_WIDTH-1:0] lanes [NUM_LANES];
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      grant;
    logic [SEL_W-1:0]      rr_grant;
    logic                  rr_any;
    logic                  has_grant;
    logic                  slot_free;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
        assign lanes[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    lane_rr_pick #(
        .NUM_LANES (NUM_LANES)
    ) u_pick (
        .req   (valid_in),
        .ptr   (ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    // The slot is free when the register is empty or its word leaves this cycle,
    // which lets a new word load in the same cycle as an output transfer.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path infers a latch.
        slot_free = !valid_out || ready_in;
        grant     = ptr;
        has_grant = valid_in[ptr];
        ready_out = '0;
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            has_grant = rr_any;
        end
        if (slot_free && has_grant) ready_out[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // sees pre-edge values regardless of statement order.
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_out  <= '0;
            ptr       <= '0;
        end else if (slot_free) begin
            if (has_grant) begin
                data_out  <= lanes[grant];
                lane_out  <= grant;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            // TDM advances on every free slot, bubbles included; RR only moves past a winner.
            if (mode == MODE_TDM) begin
                ptr <= ptr + 1'b1;
            end else if (has_grant) begin
                ptr <= grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_merge_rr.sv
// Self-checking bench for lane_merge_rr: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_lane_merge_rr;
    import lane_merge_rr_pkg::*;

    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int DW2 = 16;
    localparam int N2  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main DUT (4 lanes x 8 bits)
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_out;
    logic            mode;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic [SW-1:0]   lane_out;
    logic            ready_in;

    // Second build (2 lanes x 16 bits)
    logic [N2*DW2-1:0] data_in2;
    logic [N2-1:0]     valid_in2;
    logic [N2-1:0]     ready_out2;
    logic              mode2;
    logic [DW2-1:0]    data_out2;
    logic              valid_out2;
    logic [0:0]        lane_out2;
    logic              ready_in2;

    lane_merge_rr #(.DATA_WIDTH(DW), .NUM_LANES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mode      (mode),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .ready_in  (ready_in)
    );

    lane_merge_rr #(.DATA_WIDTH(DW2), .NUM_LANES(N2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in2),
        .valid_in  (valid_in2),
        .ready_out (ready_out2),
        .mode      (mode2),
        .data_out  (data_out2),
        .valid_out (valid_out2),
        .lane_out  (lane_out2),
        .ready_in  (ready_in2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the output register contents plus the scan pointer.
    int          m_ptr;
    logic [DW-1:0] m_data;
    int          m_lane;
    bit          m_valid;

    function automatic bit model_has();
        if (mode == MODE_TDM) return valid_in[m_ptr];
        return valid_in != '0;
    endfunction

    function automatic int model_grant();
        if (mode == MODE_TDM) return m_ptr;
        for (int k = 0; k < N; k++) begin
            if (valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_data  = '0;
        m_lane  = 0;
        m_valid = 0;
    endtask

    // Called with inputs already driven; checks ready_out, clocks once, checks outputs.
    task automatic cycle(input string tag);
        bit          sf;
        bit          hg;
        int          g;
        logic [N-1:0] one;
        logic [N-1:0] exp_ro;
        #1;
        one    = 1;
        sf     = !m_valid || ready_in;
        hg     = model_has();
        g      = model_grant();
        exp_ro = (sf && hg) ? (one << g) : '0;
        check({tag, ":ready_out"}, 32'(ready_out), 32'(exp_ro));
        if (sf) begin
            if (hg) begin
                m_data  = data_in[g*DW +: DW];
                m_lane  = g;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (mode == MODE_TDM) m_ptr = (m_ptr + 1) % N;
            else if (hg)          m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        check({tag, ":valid_out"}, 32'(valid_out), 32'(m_valid));
        check({tag, ":data_out"},  32'(data_out),  32'(m_data));
        check({tag, ":lane_out"},  32'(lane_out),  32'(m_lane));
    endtask

    task automatic set_lanes(input logic [7:0] d0, d1, d2, d3);
        data_in = {d3, d2, d1, d0};
    endtask

    logic [7:0] seq_d [5];
    int         valid_cnt;
    logic [7:0] held_d;
    logic [1:0] held_l;

    initial begin
        seq_d = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        data_in   = '0;
        valid_in  = '0;
        mode      = MODE_RR;
        ready_in  = 1'b1;
        data_in2  = '0;
        valid_in2 = '0;
        mode2     = MODE_RR;
        ready_in2 = 1'b1;
        reset     = 1'b1;
        model_reset();

        #2 reset = 1'b0;
        #1;
        check("reset:valid_out", 32'(valid_out), 0);
        check("reset:data_out",  32'(data_out),  0);
        check("reset:lane_out",  32'(lane_out),  0);
        @(negedge clk) reset = 1'b1;

        // RR, all lanes valid: strict rotation starting at lane 0
        set_lanes(8'h10, 8'h21, 8'h32, 8'h43);
        valid_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle("rr_all");
            check("rr_all:seq_data", 32'(data_out), 32'(seq_d[k]));
            check("rr_all:seq_lane", 32'(lane_out), k % 4);
        end

        // RR, lanes 1 and 3 only: alternate with no bubbles
        valid_in = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            cycle("rr_13");
            check("rr_13:no_bubble", 32'(valid_out), 1);
        end

        // TDM, lane 2 only: one word every fourth slot
        mode = MODE_TDM;
        set_lanes(8'h00, 8'h00, 8'hAA, 8'h00);
        valid_in  = 4'b0100;
        valid_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle("tdm_2");
            if (valid_out) valid_cnt++;
        end
        check("tdm_2:words_in_8", 32'(valid_cnt), 2);

        // Backpressure in RR: outputs freeze, nothing accepted
        mode = MODE_RR;
        set_lanes(8'h10, 8'h21, 8'h32, 8'h43);
        valid_in = 4'b1111;
        cycle("bp_load");
        held_d   = data_out;
        held_l   = lane_out;
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp_stall");
            check("bp_stall:data_held", 32'(data_out), 32'(held_d));
            check("bp_stall:lane_held", 32'(lane_out), 32'(held_l));
        end
        ready_in = 1'b1;
        cycle("bp_resume");
        check("bp_resume:next_lane", 32'(lane_out), 32'((held_l + 2'd1)));
        cycle("bp_resume2");

        // RR leaves ptr at 3, then TDM grants 3 then 0
        valid_in = 4'b0100;
        cycle("sw_rr");
        check("sw_rr:lane", 32'(lane_out), 2);
        mode     = MODE_TDM;
        valid_in = 4'b1111;
        cycle("sw_tdm0");
        check("sw_tdm0:lane", 32'(lane_out), 3);
        cycle("sw_tdm1");
        check("sw_tdm1:lane", 32'(lane_out), 0);

        // Randomized traffic, modes and backpressure
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            valid_in = N'($urandom);
            ready_in = ($urandom_range(0, 9) < 7);
            data_in  = $urandom;
            cycle("rand");
        end

        // Reset pulled low between edges while traffic is flowing
        mode     = MODE_RR;
        valid_in = 4'b1111;
        ready_in = 1'b1;
        set_lanes(8'h55, 8'h66, 8'h77, 8'h88);
        cycle("pre_rst");
        cycle("pre_rst");
        #3 reset = 1'b0;
        #1;
        check("mid_rst:valid_out", 32'(valid_out), 0);
        check("mid_rst:data_out",  32'(data_out),  0);
        check("mid_rst:lane_out",  32'(lane_out),  0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        cycle("post_rst");
        check("post_rst:first_lane", 32'(lane_out), 0);
        check("post_rst:first_data", 32'(data_out), 32'h55);

        // Two-lane build, RR with wrap 1 -> 0
        data_in2  = {16'hABCD, 16'h1234};
        valid_in2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("n2:ready_out", 32'(ready_out2), (k % 2 == 0) ? 1 : 2);
            @(posedge clk);
            #1;
            check("n2:valid_out", 32'(valid_out2), 1);
            check("n2:data_out",  32'(data_out2), (k % 2 == 0) ? 32'h1234 : 32'hABCD);
            check("n2:lane_out",  32'(lane_out2), k % 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
